updown_digit_counter: RTL and testbench

- Parametrised successor to the single-digit button counter.
- Holding E_Button low steps a bounded up/down counter: one step after an initial hold delay, then auto-repeat at a faster rate. Bounds saturate or wrap.
- The value is shown as multi-digit decimal on a time-multiplexed 7-segment display.
- Also provides a parametrised clock-divider output (Div_out).

---
 rtl/updown_pkg.sv | 30 +++
 rtl/seg_decoder.sv | 14 +
 rtl/updown_digit_counter.sv | 189 ++++++++++++++++++
 tb/tb_updown_digit_counter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down digit counter.
// Latency: n/a (types, constants and a constant-evaluation helper only).
// Backpressure: n/a.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [6:0] BLANK = 7'b0000000;

  // {a,b,c,d,e,f,g}, bit6 = a, active-high; codes 10..15 are dark
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  // Power of ten, used with loop constants so it folds at elaboration
  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD digit to 7-segment pattern, with forced blanking.
// Latency: combinational.
// Backpressure: none.
module seg_decoder
  import updown_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? BLANK : SEG_LUT[digit_i];

endmodule

// File: rtl/updown_digit_counter.sv
// Hold-to-step bounded up/down counter with muxed decimal display and clock divider.
// Latency: step/load visible on Count one cycle after sampling; Seg lags Count by one cycle.
// Backpressure: none; every input is sampled every cycle.
module updown_digit_counter
  import updown_pkg::*;
#(
  parameter  int MIN_VAL     = 1,
  parameter  int MAX_VAL     = 12,
  parameter  int RESET_VAL   = 1,
  parameter  int WRAP        = 0,
  parameter  int FIRST_DELAY = 1_000_000,
  parameter  int REPEAT_DIV  = 250_000,
  parameter  int DIGITS      = 2,
  parameter  int SCAN_DIV    = 50_000,
  parameter  int DIV_HALF    = 2,
  localparam int CW          = $clog2(MAX_VAL + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              E_Button,
  input  logic              Ctrl,
  input  logic              Load,
  input  logic [CW-1:0]     Load_val,
  output logic [CW-1:0]     Count,
  output logic              Limit,
  output logic [6:0]        Seg,
  output logic [DIGITS-1:0] Digit_sel,
  output logic              Div_out
);

  localparam int PMAX = (FIRST_DELAY > REPEAT_DIV) ? FIRST_DELAY : REPEAT_DIV;
  localparam int PW   = $clog2(PMAX) + 1;
  localparam int SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCW  = $clog2(SCAN_DIV) + 1;
  localparam int DW   = $clog2(DIV_HALF) + 1;
  localparam logic [3:0] RST_DIG = 4'(RESET_VAL % 10);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            step;
  logic [CW-1:0]   count_q, count_d;
  logic            limit_q, limit_d;
  logic [SCW-1:0]  scan_cnt_q;
  logic [SW-1:0]   scan_idx_q;
  logic [6:0]      seg_q, seg_w;
  logic [DIGITS-1:0] dsel_q;
  logic [DW-1:0]   div_cnt_q;
  logic            div_q;
  logic [3:0]      dig_sel;
  logic            blank_sel;

  // FSM state and prescaler registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Next state: a press arms the delay, the first step enters auto-repeat, release always idles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!E_Button) state_d = ARMED;
      ARMED:   if (E_Button) state_d = IDLE;
               else if (presc_q == PW'(FIRST_DELAY - 1)) state_d = REPEAT;
      REPEAT:  if (E_Button) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: step strobe and prescaler next value (cleared on release and on each step)
  always_comb begin
    step    = 1'b0;
    presc_d = '0;
    case (state_q)
      ARMED: if (!E_Button) begin
        if (presc_q == PW'(FIRST_DELAY - 1)) step = 1'b1;
        else presc_d = presc_q + PW'(1);
      end
      REPEAT: if (!E_Button) begin
        if (presc_q == PW'(REPEAT_DIV - 1)) step = 1'b1;
        else presc_d = presc_q + PW'(1);
      end
      default: presc_d = '0;
    endcase
  end

  // Counter next value: load (clamped) wins over a step; Limit flags any step attempted at a bound
  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    if (Load) begin
      if (Load_val < CW'(MIN_VAL))      count_d = CW'(MIN_VAL);
      else if (Load_val > CW'(MAX_VAL)) count_d = CW'(MAX_VAL);
      else                              count_d = Load_val;
    end else if (step) begin
      if (Ctrl) begin
        if (count_q < CW'(MAX_VAL)) count_d = count_q + CW'(1);
        else begin
          limit_d = 1'b1;
          if (WRAP != 0) count_d = CW'(MIN_VAL);
        end
      end else begin
        if (count_q > CW'(MIN_VAL)) count_d = count_q - CW'(1);
        else begin
          limit_d = 1'b1;
          if (WRAP != 0) count_d = CW'(MAX_VAL);
        end
      end
    end
  end

  // Count and Limit registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= CW'(RESET_VAL);
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  // Pick the decimal digit under the scan index; blank leading zeros above digit 0
  always_comb begin
    dig_sel   = 4'd0;
    blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx_q == SW'(k)) begin
        dig_sel   = 4'((int'(count_q) / pow10(k)) % 10);
        blank_sel = (k > 0) && (int'(count_q) < pow10(k));
      end
    end
  end

  seg_decoder u_dec (
    .digit_i (dig_sel),
    .blank_i (blank_sel),
    .seg_o   (seg_w)
  );

  // Scan timer and digit index, advancing every SCAN_DIV cycles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == SW'(DIGITS - 1)) ? '0 : scan_idx_q + SW'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + SCW'(1);
    end
  end

  // Display outputs registered together so the enable and pattern never disagree
  always_ff @(posedge Clk) begin
    if (Rst) begin
      seg_q  <= SEG_LUT[RST_DIG];
      dsel_q <= DIGITS'(1);
    end else begin
      seg_q  <= seg_w;
      dsel_q <= DIGITS'(1) << scan_idx_q;
    end
  end

  // Free-running divider, toggling every DIV_HALF cycles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_cnt_q <= '0;
      div_q     <= 1'b1;
    end else if (div_cnt_q == DW'(DIV_HALF - 1)) begin
      div_cnt_q <= '0;
      div_q     <= ~div_q;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  assign Count     = count_q;
  assign Limit     = limit_q;
  assign Seg       = seg_q;
  assign Digit_sel = dsel_q;
  assign Div_out   = div_q;

endmodule

// File: tb/tb_updown_digit_counter.sv
// Scoreboard bench: two instances (saturating and wrapping) share stimulus,
// a run-length reference model queues expected outputs per clock edge,
// and a monitor pops and compares after every edge.
module tb_updown_digit_counter;

  localparam int MINV = 1;
  localparam int MAXV = 12;
  localparam int RSTV = 1;
  localparam int FD   = 4;
  localparam int RD   = 2;
  localparam int SD   = 3;
  localparam int DH   = 2;
  localparam int ND   = 2;

  typedef struct packed {
    logic [3:0] count;
    logic       limit;
    logic [6:0] seg;
    logic [1:0] dsel;
    logic       div;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       E_Button = 1'b1;
  logic       Ctrl = 1'b1;
  logic       Load = 1'b0;
  logic [3:0] Load_val = 4'd0;

  logic [3:0] count0, count1;
  logic       limit0, limit1;
  logic [6:0] seg0, seg1;
  logic [1:0] dsel0, dsel1;
  logic       div0, div1;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state
  int m_count[2];
  int m_n;   // consecutive held cycles so far
  int m_k;   // clock edges since last reset

  always #5 Clk = ~Clk;

  updown_digit_counter #(
    .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV), .WRAP(0),
    .FIRST_DELAY(FD), .REPEAT_DIV(RD), .DIGITS(ND), .SCAN_DIV(SD), .DIV_HALF(DH)
  ) u_sat (
    .Clk(Clk), .Rst(Rst), .E_Button(E_Button), .Ctrl(Ctrl), .Load(Load),
    .Load_val(Load_val), .Count(count0), .Limit(limit0), .Seg(seg0),
    .Digit_sel(dsel0), .Div_out(div0)
  );

  updown_digit_counter #(
    .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV), .WRAP(1),
    .FIRST_DELAY(FD), .REPEAT_DIV(RD), .DIGITS(ND), .SCAN_DIV(SD), .DIV_HALF(DH)
  ) u_wrap (
    .Clk(Clk), .Rst(Rst), .E_Button(E_Button), .Ctrl(Ctrl), .Load(Load),
    .Load_val(Load_val), .Count(count1), .Limit(limit1), .Seg(seg1),
    .Digit_sel(dsel1), .Div_out(div1)
  );

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;
      2: return 7'b1101101;  3: return 7'b1111001;
      4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;
      8: return 7'b1111111;  9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] disp(input int c, input int idx);
    int p;
    p = (idx == 0) ? 1 : 10;
    if (idx > 0 && c < p) return 7'b0000000;
    return seg_pat((c / p) % 10);
  endfunction

  // Step fires on the held cycle that ends the first delay, then every RD held cycles
  function automatic bit step_at(input int n);
    if (n == FD + 1) return 1'b1;
    if (n > FD + 1 && ((n - FD - 1) % RD) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Apply inputs for the next edge, advance the model, queue expected outputs
  task automatic drive(input logic rst, input logic eb, input logic ct,
                       input logic ld, input logic [3:0] lv);
    exp_t e;
    int   c, nc, idx;
    bit   stp, lim;
    @(negedge Clk);
    Rst = rst; E_Button = eb; Ctrl = ct; Load = ld; Load_val = lv;
    stp = !rst && !eb && step_at(m_n + 1);
    idx = (m_k / SD) % ND;
    for (int i = 0; i < 2; i++) begin
      c = m_count[i];
      nc = c;
      lim = 1'b0;
      if (rst) begin
        nc = RSTV;
        e.seg  = disp(RSTV, 0);
        e.dsel = 2'b01;
        e.div  = 1'b1;
      end else begin
        if (ld) begin
          nc = (int'(lv) < MINV) ? MINV : (int'(lv) > MAXV) ? MAXV : int'(lv);
        end else if (stp) begin
          if (ct) begin
            if (c < MAXV) nc = c + 1;
            else begin lim = 1'b1; nc = (i == 1) ? MINV : c; end
          end else begin
            if (c > MINV) nc = c - 1;
            else begin lim = 1'b1; nc = (i == 1) ? MAXV : c; end
          end
        end
        e.seg  = disp(c, idx);
        e.dsel = 2'(1 << idx);
        e.div  = 1'b1 ^ 1'(((m_k + 1) / DH) & 1);
      end
      e.count = 4'(nc);
      e.limit = lim;
      m_count[i] = nc;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
    m_n = (rst || eb) ? 0 : m_n + 1;
    m_k = rst ? 0 : m_k + 1;
    started = 1'b1;
  endtask

  task automatic hold(input int n, input logic eb, input logic ct);
    for (int i = 0; i < n; i++) drive(1'b0, eb, ct, 1'b0, 4'd0);
  endtask

  task automatic check(input string name, input int inst, input logic [7:0] got,
                       input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, got, want);
    end
  endtask

  // Monitor: every edge presents a new output set, compare against the queued expectation
  always @(posedge Clk) begin
    #1;
    cyc++;
    if (started) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty cyc=%0d got=0 want=1", cyc);
      end else begin
        exp_t a, b;
        a = q0.pop_front();
        b = q1.pop_front();
        check("count", 0, 8'(count0), 8'(a.count));
        check("limit", 0, 8'(limit0), 8'(a.limit));
        check("seg",   0, 8'(seg0),   8'(a.seg));
        check("dsel",  0, 8'(dsel0),  8'(a.dsel));
        check("div",   0, 8'(div0),   8'(a.div));
        check("count", 1, 8'(count1), 8'(b.count));
        check("limit", 1, 8'(limit1), 8'(b.limit));
        check("seg",   1, 8'(seg1),   8'(b.seg));
        check("dsel",  1, 8'(dsel1),  8'(b.dsel));
        check("div",   1, 8'(div1),   8'(b.div));
      end
    end
  end

  logic ct_r;

  initial begin
    m_count[0] = RSTV; m_count[1] = RSTV; m_n = 0; m_k = 0;
    // Reset then idle
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(10, 1'b1, 1'b1);
    // Hold up 12 cycles, release
    hold(12, 1'b0, 1'b1);
    hold(4, 1'b1, 1'b1);
    // From 11 upward into the top bound
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd11);
    hold(14, 1'b0, 1'b1);
    hold(2, 1'b1, 1'b1);
    // From 1 downward into the bottom bound
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
    hold(12, 1'b0, 1'b0);
    hold(2, 1'b1, 1'b0);
    // Load 15 on the first step cycle, then load 0 on a repeat step
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    hold(FD, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd15);
    hold(1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    hold(2, 1'b1, 1'b1);
    // Release one cycle before the first step, then re-press
    hold(FD, 1'b0, 1'b1);
    hold(1, 1'b1, 1'b1);
    hold(FD + 4, 1'b0, 1'b1);
    // Reset while in auto-repeat, button still held
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    hold(8, 1'b0, 1'b1);
    hold(2, 1'b1, 1'b1);
    // Randomised holds with sticky direction, sporadic loads and resets
    ct_r = 1'b1;
    for (int s = 0; s < 150; s++) begin
      int len;
      len = int'($urandom_range(1, 22));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 19) == 0) ct_r = ~ct_r;
        drive(($urandom_range(0, 299) == 0), 1'b0, ct_r,
              ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
      end
      len = int'($urandom_range(1, 3));
      for (int c = 0; c < len; c++)
        drive(1'b0, 1'b1, ct_r, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end
    @(posedge Clk);
    #2;
    if (q0.size() != 0 || q1.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
